tmon_ctrl: RTL and testbench
============================

TMON_CTRL -- requirements
Module: tmon_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  controller accepts a command; transfer when cmd_valid and cmd_ready are both high.
REQ-006 cmd_op  input  4  TMOD_OP encoding: 0000 RESET, 0001 SET_FRQ, 0010 SET_HIGH_TEMP, 0011 SET_LOW_TEMP, 0100 OUT_MAX, 0101 OUT_MIN, 0110 OUT_ADDR (last sample), 0111 OUT_AVG, 1xxx NOOP.
REQ-007 cmd_data  input  8  argument for SET_* commands (DTYPE).
REQ-008 smp_req  output  1  one-cycle pulse requesting one sensor sample.
REQ-009 smp_valid  input  1  sensor sample present.
REQ-010 smp_data  input  8  unsigned temperature sample.
REQ-011 out_valid  output  1  response data valid.
REQ-012 out_data  output  8  response value.
REQ-013 out_ready  input  1  consumer accepts response.
REQ-014 status  output  2  TMOD_STATUS: 00 OK, 01 LOW, 10 HIGH.

Function
REQ-015 Sample scheduler SHALL have states S_COUNT and S_WAIT; in S_COUNT cnt increments from 0 and, when cnt == frq-1, smp_req SHALL pulse for one cycle and the FSM SHALL move to S_WAIT.
REQ-016 frq == 0 SHALL disable sampling: scheduler stays in S_COUNT with cnt held at 0 and no smp_req.
REQ-017 In S_WAIT, smp_valid SHALL capture smp_data, return to S_COUNT with cnt = 0; smp_valid in S_COUNT SHALL be ignored.
REQ-018 On a captured sample: last = smp_data; max = max(max, sample); min = min(min, sample); sample shifted into a 4-entry window.
REQ-019 The first sample after reset or RESET command SHALL fill all 4 window entries; window sum is 10 bits; avg = sum >> 2 (truncating).
REQ-020 status SHALL be registered, recomputed every cycle: HIGH if last > high_thr, else LOW if last < low_thr, else OK; a change in last or thresholds is visible one cycle later.
REQ-021 Command FSM SHALL have states C_IDLE and C_OUT; cmd_ready = 1 only in C_IDLE.
REQ-022 SET_FRQ SHALL load frq and restart the scheduler in S_COUNT with cnt = 0, abandoning any pending S_WAIT.
REQ-023 SET_HIGH_TEMP / SET_LOW_TEMP SHALL load high_thr / low_thr; no range check against each other (HIGH wins on overlap).
REQ-024 OUT_* SHALL register the selected value into out_data on the accept edge, assert out_valid next cycle, enter C_OUT; out_valid and out_data SHALL hold until out_valid and out_ready, then return to C_IDLE.
REQ-025 OUT_* SHALL report statistics as they stood before any sample captured in the same cycle.
REQ-026 RESET command SHALL restore max, min, last, window, first-sample flag, frq, thresholds and scheduler to reset values; same-cycle smp_valid SHALL be discarded.
REQ-027 NOOP (1xxx) SHALL be accepted in one cycle with no effect.
REQ-028 Sampling SHALL continue independently of command state, including while in C_OUT.

Reset
REQ-029 On rst_n low: cmd_ready=0 while low then 1 after release, smp_req=0, out_valid=0, out_data=0x00, status=OK, frq=10, high_thr=0xFF, low_thr=0x00, max=0x00, min=0xFF, last=0x00, window=0, cnt=0, S_COUNT, C_IDLE.
REQ-030 Reset asserted mid-handshake SHALL drop out_valid and abandon pending sample request immediately.

Verification
REQ-031 Release reset, no commands -> smp_req pulses on the 10th clock edge after release; respond smp_data=0x30 -> OUT_ADDR returns 0x30, OUT_AVG returns 0x30.
REQ-032 Samples 0x10,0x20,0x30,0x40 -> OUT_MAX=0x40, OUT_MIN=0x10, OUT_AVG=0x28; then 0x50 -> OUT_AVG=0x38.
REQ-033 SET_HIGH_TEMP 0x40, SET_LOW_TEMP 0x20, samples 0x41, 0x1F, 0x30 -> status HIGH, LOW, OK each one cycle after capture.
REQ-034 OUT_MAX with out_ready low 5 cycles -> out_valid and out_data stable, cmd_ready 0, next cmd_valid not accepted until handshake.
REQ-035 SET_FRQ 0 -> no smp_req for 100 cycles; SET_FRQ 3 -> smp_req every 3 cycles plus response latency.
REQ-036 RESET command coincident with smp_valid=0xAA -> OUT_MAX 0x00, OUT_MIN 0xFF, status OK, frq back to 10.

Source files
------------

// File: rtl/tmon_ctrl.sv
// Temperature monitor controller: periodic sensor sampling, running statistics
// (last/max/min/4-sample average), threshold status and a command/response port.
module tmon_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       smp_req,
    input  logic       smp_valid,
    input  logic [7:0] smp_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [1:0] status
);
    typedef enum logic {S_COUNT, S_WAIT} sched_e;
    typedef enum logic {C_IDLE, C_OUT} cmd_e;

    localparam logic [7:0] FRQ_RST = 8'd10;

    sched_e     s_q, s_d;
    cmd_e       c_q, c_d;
    logic [7:0] cnt_q, cnt_d, frq_q, frq_d;
    logic [7:0] hi_q, hi_d, lo_q, lo_d;
    logic [7:0] max_q, max_d, min_q, min_d, last_q, last_d;
    logic [7:0] win_q [4];
    logic [7:0] win_d [4];
    logic       first_q, first_d;
    logic       smp_req_q, smp_req_d;
    logic       out_valid_q, out_valid_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic [7:0] out_data_q, out_data_d;
    logic [1:0] status_q, status_d;

    logic       acc, restart, cap;
    logic [9:0] sum;
    logic [7:0] sel;

    always_comb begin
        acc     = cmd_valid && cmd_ready_q;
        // RESET and SET_FRQ both restart the scheduler, so a coincident sample is dropped
        restart = acc && (cmd_op[3:1] == 3'b000);
        cap     = (s_q == S_WAIT) && smp_valid && !restart;
        sum     = 10'(win_q[0]) + 10'(win_q[1]) + 10'(win_q[2]) + 10'(win_q[3]);
        case (cmd_op[1:0])
            2'b00:   sel = max_q;
            2'b01:   sel = min_q;
            2'b10:   sel = last_q;
            default: sel = sum[9:2];
        endcase

        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        frq_d       = frq_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        max_d       = max_q;
        min_d       = min_q;
        last_d      = last_q;
        win_d       = win_q;
        first_d     = first_q;
        smp_req_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (s_q == S_COUNT) begin
            if (frq_q == 8'd0) begin
                cnt_d = 8'd0;
            end else if (cnt_q == frq_q - 8'd1) begin
                smp_req_d = 1'b1;
                s_d       = S_WAIT;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (smp_valid) begin
            s_d   = S_COUNT;
            cnt_d = 8'd0;
        end

        if (cap) begin
            last_d = smp_data;
            max_d  = (smp_data > max_q) ? smp_data : max_q;
            min_d  = (smp_data < min_q) ? smp_data : min_q;
            if (first_q) begin
                for (int i = 0; i < 4; i++) win_d[i] = smp_data;
            end else begin
                win_d[0] = smp_data;
                for (int i = 1; i < 4; i++) win_d[i] = win_q[i-1];
            end
            first_d = 1'b0;
        end

        case (c_q)
            C_IDLE: begin
                if (acc) begin
                    case (cmd_op)
                        4'b0000: begin
                            frq_d     = FRQ_RST;
                            hi_d      = 8'hFF;
                            lo_d      = 8'h00;
                            max_d     = 8'h00;
                            min_d     = 8'hFF;
                            last_d    = 8'h00;
                            for (int i = 0; i < 4; i++) win_d[i] = 8'h00;
                            first_d   = 1'b1;
                            s_d       = S_COUNT;
                            cnt_d     = 8'd0;
                            smp_req_d = 1'b0;
                        end
                        4'b0001: begin
                            frq_d     = cmd_data;
                            s_d       = S_COUNT;
                            cnt_d     = 8'd0;
                            smp_req_d = 1'b0;
                        end
                        4'b0010: hi_d = cmd_data;
                        4'b0011: lo_d = cmd_data;
                        4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                            out_data_d  = sel;
                            out_valid_d = 1'b1;
                            c_d         = C_OUT;
                        end
                        default: ;
                    endcase
                end
            end
            C_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    c_d         = C_IDLE;
                end
            end
            default: ;
        endcase

        cmd_ready_d = (c_d == C_IDLE);

        if (last_q > hi_q)      status_d = 2'b10;
        else if (last_q < lo_q) status_d = 2'b01;
        else                    status_d = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= S_COUNT;
            c_q         <= C_IDLE;
            cnt_q       <= 8'd0;
            frq_q       <= FRQ_RST;
            hi_q        <= 8'hFF;
            lo_q        <= 8'h00;
            max_q       <= 8'h00;
            min_q       <= 8'hFF;
            last_q      <= 8'h00;
            for (int i = 0; i < 4; i++) win_q[i] <= 8'h00;
            first_q     <= 1'b1;
            smp_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            cmd_ready_q <= 1'b0;
            status_q    <= 2'b00;
        end else begin
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            frq_q       <= frq_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            max_q       <= max_d;
            min_q       <= min_d;
            last_q      <= last_d;
            win_q       <= win_d;
            first_q     <= first_d;
            smp_req_q   <= smp_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cmd_ready_q <= cmd_ready_d;
            status_q    <= status_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign smp_req   = smp_req_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign status    = status_q;
endmodule

// File: tb/tb_tmon_ctrl.sv
// Bench for tmon_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a sample-history reference model.
module tb_tmon_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_op = 4'h8;
    logic [7:0] cmd_data = 8'h00;
    logic       smp_req, smp_valid = 1'b0;
    logic [7:0] smp_data = 8'h00;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_data;
    logic [1:0] status;

    always #5 clk = ~clk;

    tmon_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .smp_req(smp_req), .smp_valid(smp_valid), .smp_data(smp_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .status(status)
    );

    int n_vec = 0, n_err = 0;

    task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: statistics derived from the list of captured samples,
    // sample timing from the absolute edge at which the next request is due.
    int         t, m_req_at;
    bit         m_waiting, m_busy, m_ready, m_ovalid, m_req;
    logic [7:0] m_frq, m_hi, m_lo, m_odata;
    logic [1:0] m_status;
    logic [7:0] hist [$];

    function automatic logic [7:0] f_last();
        return (hist.size() == 0) ? 8'h00 : hist[hist.size()-1];
    endfunction
    function automatic logic [7:0] f_max();
        logic [7:0] m = 8'h00;
        foreach (hist[i]) if (hist[i] > m) m = hist[i];
        return m;
    endfunction
    function automatic logic [7:0] f_min();
        logic [7:0] m = 8'hFF;
        foreach (hist[i]) if (hist[i] < m) m = hist[i];
        return m;
    endfunction
    function automatic logic [7:0] f_avg();
        int s = 0;
        int idx;
        if (hist.size() == 0) return 8'h00;
        for (int i = 0; i < 4; i++) begin
            idx = hist.size() - 1 - i;
            if (idx < 0) idx = 0;
            s += int'(hist[idx]);
        end
        return 8'(s / 4);
    endfunction

    task automatic model_init();
        t = 0; m_req_at = 10; m_waiting = 0; m_busy = 0; m_ready = 0;
        m_ovalid = 0; m_req = 0; m_frq = 8'd10; m_hi = 8'hFF; m_lo = 8'h00;
        m_odata = 8'h00; m_status = 2'b00;
        hist.delete();
    endtask

    task automatic model_edge(input bit cv, input logic [3:0] op, input logic [7:0] dat,
                              input bit sv, input logic [7:0] sd, input bit ordy);
        logic [1:0] st_n;
        bit acc, cap;
        t++;
        st_n = (f_last() > m_hi) ? 2'b10 : (f_last() < m_lo) ? 2'b01 : 2'b00;
        acc  = cv && m_ready;
        cap  = m_waiting && sv;
        m_req = (t == m_req_at);
        if (m_busy) begin
            if (ordy) begin m_busy = 0; m_ovalid = 0; end
        end else if (acc) begin
            if (op == 4'd0) begin
                hist.delete(); m_frq = 8'd10; m_hi = 8'hFF; m_lo = 8'h00;
                m_waiting = 0; cap = 0; m_req = 0; m_req_at = t + 10;
            end else if (op == 4'd1) begin
                m_frq = dat; m_waiting = 0; cap = 0; m_req = 0;
                m_req_at = (dat == 0) ? -1 : t + int'(dat);
            end else if (op == 4'd2) m_hi = dat;
            else if (op == 4'd3) m_lo = dat;
            else if (op <= 4'd7) begin
                case (op)
                    4'd4:    m_odata = f_max();
                    4'd5:    m_odata = f_min();
                    4'd6:    m_odata = f_last();
                    default: m_odata = f_avg();
                endcase
                m_ovalid = 1; m_busy = 1;
            end
        end
        if (cap) begin
            hist.push_back(sd); m_waiting = 0;
            m_req_at = (m_frq == 0) ? -1 : t + int'(m_frq);
        end else if (m_req) m_waiting = 1;
        m_ready  = !m_busy;
        m_status = st_n;
    endtask

    task automatic check_all();
        check8("cmd_ready", 8'(cmd_ready), 8'(m_ready));
        check8("smp_req", 8'(smp_req), 8'(m_req));
        check8("out_valid", 8'(out_valid), 8'(m_ovalid));
        check8("out_data", out_data, m_odata);
        check8("status", 8'(status), 8'(m_status));
    endtask

    task automatic step(input bit cv, input logic [3:0] op, input logic [7:0] dat,
                        input bit sv, input logic [7:0] sd, input bit ordy);
        cmd_valid = cv; cmd_op = op; cmd_data = dat;
        smp_valid = sv; smp_data = sd; out_ready = ordy;
        @(posedge clk);
        model_edge(cv, op, dat, sv, sd, ordy);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h8, 8'h00, 0, 8'h00, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; cmd_valid = 0; smp_valid = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        check8("rst_cmd_ready", 8'(cmd_ready), 8'h00);
        check8("rst_smp_req", 8'(smp_req), 8'h00);
        check8("rst_out_valid", 8'(out_valid), 8'h00);
        check8("rst_out_data", out_data, 8'h00);
        check8("rst_status", 8'(status), 8'h00);
        rst_n = 1'b1;
        model_init();
    endtask

    task automatic feed(input logic [7:0] sd);
        int k = 0;
        while (!m_waiting && k < 300) begin idle(1); k++; end
        check8("feed_wait", 8'(m_waiting), 8'h01);
        step(0, 4'h8, 8'h00, 1, sd, 1);
    endtask

    task automatic do_out(input logic [3:0] op, input logic [7:0] exp, input string tag);
        step(1, op, 8'h00, 0, 8'h00, 0);
        check8({tag, "_valid"}, 8'(out_valid), 8'h01);
        check8(tag, out_data, exp);
        step(0, 4'h8, 8'h00, 0, 8'h00, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int pulses, k;
        logic [3:0] op;
        logic [7:0] dat;

        apply_reset();

        idle(9);
        check8("req_before_10th", 8'(smp_req), 8'h00);
        idle(1);
        check8("req_on_10th", 8'(smp_req), 8'h01);
        step(0, 4'h8, 8'h00, 1, 8'h30, 1);
        do_out(4'd6, 8'h30, "first_addr");
        do_out(4'd7, 8'h30, "first_avg");

        apply_reset();
        feed(8'h10); feed(8'h20); feed(8'h30); feed(8'h40);
        do_out(4'd4, 8'h40, "max4");
        do_out(4'd5, 8'h10, "min4");
        do_out(4'd7, 8'h28, "avg4");
        feed(8'h50);
        do_out(4'd7, 8'h38, "avg5");

        step(1, 4'd2, 8'h40, 0, 8'h00, 1);
        step(1, 4'd3, 8'h20, 0, 8'h00, 1);
        feed(8'h41); idle(1); check8("status_high", 8'(status), 8'h02);
        feed(8'h1F); idle(1); check8("status_low", 8'(status), 8'h01);
        feed(8'h30); idle(1); check8("status_ok", 8'(status), 8'h00);

        step(1, 4'd4, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'd5, 8'h00, 0, 8'h00, 0);
            check8("hold_valid", 8'(out_valid), 8'h01);
            check8("hold_data", out_data, 8'h50);
            check8("hold_ready", 8'(cmd_ready), 8'h00);
        end
        step(1, 4'd5, 8'h00, 0, 8'h00, 1);
        check8("handshake_done", 8'(out_valid), 8'h00);
        step(1, 4'd5, 8'h00, 0, 8'h00, 0);
        check8("next_cmd_min", out_data, 8'h10);
        idle(1);

        step(1, 4'd1, 8'h00, 0, 8'h00, 1);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin idle(1); pulses += int'(smp_req); end
        check8("frq0_pulses", 8'(pulses), 8'h00);
        step(1, 4'd1, 8'h03, 0, 8'h00, 1);
        idle(2); check8("frq3_early", 8'(smp_req), 8'h00);
        idle(1); check8("frq3_pulse", 8'(smp_req), 8'h01);
        step(0, 4'h8, 8'h00, 1, 8'h55, 1);
        idle(2); check8("frq3_early2", 8'(smp_req), 8'h00);
        idle(1); check8("frq3_pulse2", 8'(smp_req), 8'h01);

        step(1, 4'd0, 8'h00, 1, 8'hAA, 1);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin idle(1); pulses += int'(smp_req); end
        check8("rstcmd_no_early_req", 8'(pulses), 8'h00);
        idle(1); check8("rstcmd_frq10", 8'(smp_req), 8'h01);
        check8("rstcmd_status", 8'(status), 8'h00);
        do_out(4'd4, 8'h00, "rstcmd_max");
        do_out(4'd5, 8'hFF, "rstcmd_min");

        feed(8'h77);
        step(1, 4'd4, 8'h00, 0, 8'h00, 0);
        k = 0;
        while (!smp_req && k < 30) begin step(0, 4'h8, 8'h00, 0, 8'h00, 0); k++; end
        check8("midhs_req_seen", 8'(smp_req), 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check8("midhs_out_valid", 8'(out_valid), 8'h00);
        check8("midhs_smp_req", 8'(smp_req), 8'h00);
        check8("midhs_cmd_ready", 8'(cmd_ready), 8'h00);
        @(negedge clk);
        apply_reset();

        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd0 && $urandom_range(0, 3) != 0) op = 4'h8;
            dat = (op == 4'd1) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) == 0, op, dat, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
